// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, requester ids, states.
package alu_arbiter_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned CNT_W = 16;

    // ALU operation encodings
    localparam logic [OP_W-1:0] ALU_AND  = 4'd0;
    localparam logic [OP_W-1:0] ALU_OR   = 4'd1;
    localparam logic [OP_W-1:0] ALU_ADDU = 4'd2;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'd3;
    localparam logic [OP_W-1:0] ALU_NOR  = 4'd4;
    localparam logic [OP_W-1:0] ALU_SUBU = 4'd6;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'd7;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'd8;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'd9;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'd10;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'd11;

    // Requester ids
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Result register occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU; shifts use the low log2(WIDTH) bits of B.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OP_W-1:0]  ALUop,
    output logic [WIDTH-1:0] Out
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    logic [SH_W-1:0] shamt;
    assign shamt = B[SH_W-1:0];

    // Operation select; unknown opcodes yield zero
    always_comb begin
        Out = '0;
        case (ALUop)
            ALU_AND:  Out = A & B;
            ALU_OR:   Out = A | B;
            ALU_ADDU: Out = A + B;
            ALU_XOR:  Out = A ^ B;
            ALU_NOR:  Out = ~(A | B);
            ALU_SUBU: Out = A - B;
            ALU_SLT:  Out = WIDTH'($signed(A) < $signed(B));
            ALU_SLTU: Out = WIDTH'(A < B);
            ALU_SLL:  Out = A << shamt;
            ALU_SRL:  Out = A >> shamt;
            ALU_SRA:  Out = $unsigned($signed(A) >>> shamt);
            default:  Out = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters,
// with a single registered result slot and per-requester accept counters.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_A,
    input  logic [WIDTH-1:0]  req0_B,
    input  logic [OP_W-1:0]   req0_ALUop,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_A,
    input  logic [WIDTH-1:0]  req1_B,
    input  logic [OP_W-1:0]   req1_ALUop,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [WIDTH-1:0]  resp_data,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    state_e            state;
    state_e            state_nx;
    logic              last_grant;
    logic              slot_free;
    logic              gnt0;
    logic              gnt1;
    logic              accept;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [WIDTH-1:0]  alu_out;

    assign resp_valid = (state == FULL);
    assign slot_free  = !resp_valid || resp_ready;

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!Reset && slot_free) begin
            gnt0 = req0_valid && (!req1_valid || (last_grant == REQ1));
            gnt1 = req1_valid && (!req0_valid || (last_grant == REQ0));
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 || gnt1;

    // Operand mux into the shared ALU; idle operands are zero
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (gnt0) begin
            alu_a  = req0_A;
            alu_b  = req0_B;
            alu_op = req0_ALUop;
        end else if (gnt1) begin
            alu_a  = req1_A;
            alu_b  = req1_B;
            alu_op = req1_ALUop;
        end
    end

    alu_arbiter_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .A     (alu_a),
        .B     (alu_b),
        .ALUop (alu_op),
        .Out   (alu_out)
    );

    // Result slot state register
    always_ff @(posedge Clock) begin
        if (Reset) state <= EMPTY;
        else       state <= state_nx;
    end

    // Result slot next state: fill on accept, empty on drain without refill
    always_comb begin
        state_nx = state;
        case (state)
            EMPTY:   if (accept) state_nx = FULL;
            FULL:    if (!accept && resp_ready) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    // Result payload, round-robin pointer and accept counters
    always_ff @(posedge Clock) begin
        if (Reset) begin
            resp_data  <= '0;
            resp_id    <= REQ0;
            last_grant <= REQ1;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (accept) begin
                resp_data  <= alu_out;
                resp_id    <= gnt1 ? REQ1 : REQ0;
                last_grant <= gnt1 ? REQ1 : REQ0;
            end
            if (gnt0) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (gnt1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int unsigned WIDTH = 32;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [WIDTH-1:0]  req0_A, req0_B, req1_A, req1_B;
    logic [OP_W-1:0]   req0_ALUop, req1_ALUop;
    logic              resp_valid, resp_ready, resp_id;
    logic [WIDTH-1:0]  resp_data;
    logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_A     (req0_A),
        .req0_B     (req0_B),
        .req0_ALUop (req0_ALUop),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_A     (req1_A),
        .req1_B     (req1_B),
        .req1_ALUop (req1_ALUop),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Let combinational outputs settle after an input change
    task automatic settle();
        #1;
    endtask

    initial begin
        logic exp_g;

        Reset = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b1; req0_A = '0; req0_B = '0; req0_ALUop = ALU_ADDU;
        req1_valid = 1'b1; req1_A = '0; req1_B = '0; req1_ALUop = ALU_ADDU;
        settle();
        check("rst_rdy0", 32'(req0_ready), 32'd0);
        check("rst_rdy1", 32'(req1_ready), 32'd0);
        tick(); tick();
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_id",    32'(resp_id),    32'd0);
        check("rst_data",  resp_data,       32'd0);
        check("rst_cnt0",  32'(grant_cnt0), 32'd0);
        check("rst_cnt1",  32'(grant_cnt1), 32'd0);

        // Lone req0 ADDU 5+3
        Reset = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
        req0_A = 32'd5; req0_B = 32'd3; req0_ALUop = ALU_ADDU;
        settle();
        check("add_rdy0", 32'(req0_ready), 32'd1);
        check("add_rdy1", 32'(req1_ready), 32'd0);
        tick();
        check("add_valid", 32'(resp_valid), 32'd1);
        check("add_id",    32'(resp_id),    32'd0);
        check("add_data",  resp_data,       32'h0000_0008);
        check("add_cnt0",  32'(grant_cnt0), 32'd1);

        // Lone req1 SUBU 0-1
        req0_valid = 1'b0; req1_valid = 1'b1;
        req1_A = 32'd0; req1_B = 32'd1; req1_ALUop = ALU_SUBU;
        settle();
        check("sub_rdy1", 32'(req1_ready), 32'd1);
        tick();
        check("sub_data", resp_data,       32'hFFFF_FFFF);
        check("sub_id",   32'(resp_id),    32'd1);
        check("sub_cnt1", 32'(grant_cnt1), 32'd1);

        // Both valid, drain every cycle: alternate starting with req0 (req1 was last)
        req0_valid = 1'b1; req0_A = 32'd1;  req0_B = 32'd1;  req0_ALUop = ALU_ADDU;
        req1_valid = 1'b1; req1_A = 32'd10; req1_B = 32'd10; req1_ALUop = ALU_ADDU;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 1);
            settle();
            check("rr_rdy0", 32'(req0_ready), 32'(!exp_g));
            check("rr_rdy1", 32'(req1_ready), 32'(exp_g));
            tick();
            check("rr_id",   32'(resp_id),    32'(exp_g));
            check("rr_data", resp_data,       exp_g ? 32'd20 : 32'd2);
        end
        check("rr_cnt0", 32'(grant_cnt0), 32'd3);
        check("rr_cnt1", 32'(grant_cnt1), 32'd3);

        // Stall: held result from req1 stays put, no grants
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("stall_rdy0", 32'(req0_ready), 32'd0);
            check("stall_rdy1", 32'(req1_ready), 32'd0);
            tick();
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_id",    32'(resp_id),    32'd1);
            check("stall_data",  resp_data,       32'd20);
        end
        resp_ready = 1'b1;
        settle();
        check("unstall_rdy0", 32'(req0_ready), 32'd1);
        check("unstall_rdy1", 32'(req1_ready), 32'd0);
        tick();
        check("unstall_valid", 32'(resp_valid), 32'd1);
        check("unstall_id",    32'(resp_id),    32'd0);
        check("unstall_data",  resp_data,       32'd2);
        check("unstall_cnt0",  32'(grant_cnt0), 32'd4);
        check("unstall_cnt1",  32'(grant_cnt1), 32'd3);

        // Drain with no new request empties the slot
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check("drain_valid", 32'(resp_valid), 32'd0);

        // Fill from req0 (last_grant -> 0), then reset while full
        req0_valid = 1'b1; req0_A = 32'h0000_F0F0; req0_B = 32'h0000_FF00; req0_ALUop = ALU_AND;
        resp_ready = 1'b0;
        tick();
        check("and_valid", 32'(resp_valid), 32'd1);
        check("and_data",  resp_data,       32'h0000_F000);
        Reset = 1'b1; req1_valid = 1'b1;
        settle();
        check("rst2_rdy0", 32'(req0_ready), 32'd0);
        check("rst2_rdy1", 32'(req1_ready), 32'd0);
        tick();
        check("rst2_valid", 32'(resp_valid), 32'd0);
        check("rst2_data",  resp_data,       32'd0);
        check("rst2_cnt0",  32'(grant_cnt0), 32'd0);
        check("rst2_cnt1",  32'(grant_cnt1), 32'd0);

        // First tie after reset goes to req0
        Reset = 1'b0; resp_ready = 1'b1;
        req0_A = 32'h0000_00FF; req0_B = 32'h0000_000F; req0_ALUop = ALU_XOR;
        req1_A = 32'hFFFF_FFFF; req1_B = 32'h0000_0001; req1_ALUop = ALU_SLT;
        settle();
        check("tie_rdy0", 32'(req0_ready), 32'd1);
        check("tie_rdy1", 32'(req1_ready), 32'd0);
        tick();
        check("xor_id",   32'(resp_id), 32'd0);
        check("xor_data", resp_data,    32'h0000_00F0);
        tick();
        check("slt_id",   32'(resp_id), 32'd1);
        check("slt_data", resp_data,    32'd1);

        // Arithmetic shift on req1 alone
        req0_valid = 1'b0;
        req1_A = 32'h8000_0000; req1_B = 32'd4; req1_ALUop = ALU_SRA;
        tick();
        check("sra_data", resp_data, 32'hF800_0000);

        // Counter wrap: 65535 req0 accepts then one more
        Reset = 1'b1; req1_valid = 1'b0;
        tick();
        Reset = 1'b0; req0_valid = 1'b1; req0_ALUop = ALU_ADDU;
        repeat (65535) tick();
        check("wrap_pre_cnt0", 32'(grant_cnt0), 32'h0000_FFFF);
        check("wrap_pre_cnt1", 32'(grant_cnt1), 32'd0);
        tick();
        check("wrap_cnt0", 32'(grant_cnt0), 32'h0000_0000);
        check("wrap_cnt1", 32'(grant_cnt1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
